// File: rtl/intctrl_pkg.sv
// intctrl_pkg: constants and helpers shared by the interrupt controller and
// the CPU. Holds the controller state encoding, the vector-table defaults and
// the fixed-priority winner selection.
package intctrl_pkg;

  // Controller state encoding, shared with the CPU's debug and trace logic.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_TAKE    = 2'b01;
  localparam logic [1:0] ST_SERVICE = 2'b10;

  // Each vector slot is four instructions wide.
  localparam int unsigned VSHIFT = 2;

  localparam logic [9:0]  VBASE_DEFAULT = 10'h3F0;
  localparam int unsigned NIRQ_DEFAULT  = 4;

  // Lowest set index wins. With no bits set the result is 0, and callers
  // only use it when at least one bit is set.
  function automatic logic [1:0] prio_winner(input logic [3:0] cand);
    logic [1:0] win;
    casez (cand)
      4'b???1: win = 2'd0;
      4'b??10: win = 2'd1;
      4'b?100: win = 2'd2;
      4'b1000: win = 2'd3;
      default: win = 2'd0;
    endcase
    return win;
  endfunction

  // Vector address for a line. The sum wraps modulo 1024.
  function automatic logic [9:0] vec_addr(input logic [9:0] base, input logic [1:0] id);
    logic [9:0] offs;
    offs = {8'b0000_0000, id} << VSHIFT;
    return base + offs;
  endfunction

endpackage

// File: rtl/intctrl_irqsync.sv
// irqsync: synchroniser and rising-edge detector for one request line.
//   clk    in  system clock
//   reset  in  synchronous reset, active low
//   irq_in in  asynchronous request line
//   rise   out one-cycle pulse when the synchronised line goes 0 -> 1
module irqsync
  import intctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  // Next-state logic for the synchroniser chain and the delay flop.
  always_comb begin
    s1_d = irq_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchroniser and delay registers. Reset clears the whole chain, so a line
  // that is already high when reset releases gives exactly one rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/intctrl.sv
// intctrl: vectored interrupt controller for the 8-bit CPU.
// Latches rising request edges as pending, picks the lowest-index enabled
// pending line at an instruction boundary, and issues a one-cycle take pulse
// with the vector. A new take is blocked until the CPU executes reti.
//   clk, reset       clock, synchronous active-low reset
//   irq[NIRQ]        asynchronous requests, rising-edge sensitive
//   boundary         CPU can accept an interrupt this cycle
//   reti             return-from-interrupt pulse
//   mask_we/mask_wd  enable-mask write
//   int_take         one-cycle take pulse (registered)
//   vector           VBASE + active_id*4 (registered)
//   active_id        line being serviced (registered)
//   pending, mask    latched edges and enable mask
//   in_service       high while taking or servicing (registered)
//   err              sticky: reti seen outside SERVICE
module intctrl
  import intctrl_pkg::*;
#(
  parameter int unsigned NIRQ  = NIRQ_DEFAULT,
  parameter logic [9:0]  VBASE = VBASE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            boundary,
  input  logic            reti,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wd,
  output logic            int_take,
  output logic [9:0]      vector,
  output logic [1:0]      active_id,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] mask,
  output logic            in_service,
  output logic            err
);

  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] cand;
  logic [NIRQ-1:0] clr;
  logic [1:0]      winner;

  logic [1:0]      state_q, state_d;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic [1:0]      active_id_q, active_id_d;
  logic [9:0]      vector_q, vector_d;
  logic            int_take_q, int_take_d;
  logic            in_service_q, in_service_d;
  logic            err_q, err_d;

  for (genvar gi = 0; gi < NIRQ; gi++) begin : g_sync
    irqsync u_sync (
      .clk    (clk),
      .reset  (reset),
      .irq_in (irq[gi]),
      .rise   (rise[gi])
    );
  end

  // Selection uses the registered mask, so a mask write in the same cycle
  // only affects the next selection.
  assign cand   = pending_q & mask_q;
  assign winner = prio_winner(cand);

  // FSM, pending/mask update and the next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    clr         = {NIRQ{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if ((cand != {NIRQ{1'b0}}) && boundary) begin
          state_d     = ST_TAKE;
          active_id_d = winner;
          clr         = {{(NIRQ-1){1'b0}}, 1'b1} << winner;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TAKE: begin
        state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (reti) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // OR-ing rise in after the clear lets a coincident new edge stay pending.
    pending_d = (pending_q & ~clr) | rise;

    if (mask_we) begin
      mask_d = mask_wd;
    end else begin
      mask_d = mask_q;
    end

    err_d = err_q | (reti & (state_q != ST_SERVICE));

    // Outputs are computed from the next state so they line up with it.
    int_take_d   = (state_d == ST_TAKE);
    in_service_d = (state_d == ST_TAKE) || (state_d == ST_SERVICE);
    vector_d     = vec_addr(VBASE, active_id_d);
  end

  // State and output registers. Reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pending_q    <= {NIRQ{1'b0}};
      mask_q       <= {NIRQ{1'b0}};
      active_id_q  <= 2'd0;
      vector_q     <= VBASE;
      int_take_q   <= 1'b0;
      in_service_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      active_id_q  <= active_id_d;
      vector_q     <= vector_d;
      int_take_q   <= int_take_d;
      in_service_q <= in_service_d;
      err_q        <= err_d;
    end
  end

  assign int_take   = int_take_q;
  assign vector     = vector_q;
  assign active_id  = active_id_q;
  assign pending    = pending_q;
  assign mask       = mask_q;
  assign in_service = in_service_q;
  assign err        = err_q;

endmodule
